// File: rtl/usb_pkg.sv
// Shared USB constants: PIDs, packet kinds, CRC16 parameters, receive states.
package usb_pkg;

    localparam logic [3:0] PID_OUT   = 4'h1;
    localparam logic [3:0] PID_IN    = 4'h9;
    localparam logic [3:0] PID_SOF   = 4'h5;
    localparam logic [3:0] PID_SETUP = 4'hD;
    localparam logic [3:0] PID_DATA0 = 4'h3;
    localparam logic [3:0] PID_DATA1 = 4'hB;
    localparam logic [3:0] PID_ACK   = 4'h2;
    localparam logic [3:0] PID_NAK   = 4'hA;
    localparam logic [3:0] PID_STALL = 4'hE;

    localparam logic [1:0] KIND_SPECIAL   = 2'b00;
    localparam logic [1:0] KIND_TOKEN     = 2'b01;
    localparam logic [1:0] KIND_HANDSHAKE = 2'b10;
    localparam logic [1:0] KIND_DATA      = 2'b11;

    localparam logic [15:0] CRC16_POLY     = 16'hA001;
    localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUAL = 16'hB001;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PID,
        ST_BODY,
        ST_DONE
    } rx_state_t;

endpackage

// File: rtl/usb_crc16_byte.sv
// Combinational USB CRC16 step over one byte, LSB first (reflected form).
module usb_crc16_byte
    import usb_pkg::*;
(
    input  logic [15:0] crc,
    input  logic [7:0]  data,
    output logic [15:0] crc_next
);

    always_comb begin
        crc_next = crc;
        for (int i = 0; i < 8; i++) begin
            if (crc_next[0] ^ data[i])
                crc_next = (crc_next >> 1) ^ CRC16_POLY;
            else
                crc_next = crc_next >> 1;
        end
    end

endmodule

// File: rtl/usb_rx_check.sv
// USB receive packet checker: PID validation, length count, CRC16 residual check.
// Optional statistics counters are built when USB_RX_STATS_EN is defined.
module usb_rx_check
    import usb_pkg::*;
#(
    parameter int MAX_LEN = 67,
    parameter int LEN_W   = 7
) (
    input  logic             clk60m,
    input  logic             reset_n,
    input  logic             rx_sop,
    input  logic [7:0]       rx_byte,
    input  logic             rx_byte_valid,
    input  logic             rx_eop,
    input  logic             rx_abort,
    output logic             busy,
    output logic             pkt_done,
    output logic [3:0]       pkt_pid,
    output logic [1:0]       pkt_kind,
    output logic [LEN_W-1:0] pkt_len,
    output logic             pid_ok,
    output logic             crc_ok,
    output logic             len_err,
    output logic             aborted,
    output logic             data_toggle
`ifdef USB_RX_STATS_EN
    ,
    input  logic             stats_clr,
    output logic [15:0]      err_cnt,
    output logic [15:0]      pkt_cnt
`endif
);

    localparam logic [LEN_W-1:0] CNT_MAX = '1;

    rx_state_t        state, state_nxt;
    logic [LEN_W-1:0] cnt, cnt_nxt;
    logic [15:0]      crc, crc_nxt, crc_upd;
    logic [3:0]       cur_pid, pid_nxt;
    logic             cur_ok, ok_nxt;
    logic             finish;
    logic             len_big;
    logic             good;

    usb_crc16_byte u_crc (
        .crc      (crc),
        .data     (rx_byte),
        .crc_next (crc_upd)
    );

    assign busy     = (state == ST_PID) || (state == ST_BODY);
    assign pkt_done = (state == ST_DONE);

    // A same-cycle byte is folded in before EOP/abort closes the packet.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        crc_nxt   = crc;
        pid_nxt   = cur_pid;
        ok_nxt    = cur_ok;
        finish    = 1'b0;
        unique case (state)
            ST_IDLE: ;
            ST_PID, ST_BODY: begin
                if (rx_byte_valid) begin
                    if (state == ST_PID) begin
                        pid_nxt   = rx_byte[3:0];
                        ok_nxt    = (rx_byte[7:4] == ~rx_byte[3:0]);
                        cnt_nxt   = LEN_W'(1);
                        state_nxt = ST_BODY;
                    end else begin
                        crc_nxt = crc_upd;
                        if (cnt != CNT_MAX)
                            cnt_nxt = cnt + LEN_W'(1);
                    end
                end
                if (rx_eop || rx_abort) begin
                    state_nxt = ST_DONE;
                    finish    = 1'b1;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
        endcase
        if (rx_sop) begin
            state_nxt = ST_PID;
            cnt_nxt   = '0;
            crc_nxt   = CRC16_INIT;
            pid_nxt   = 4'h0;
            ok_nxt    = 1'b0;
            finish    = 1'b0;
        end
    end

    always_comb begin
        len_big = int'(cnt_nxt) > MAX_LEN;
        unique case (pid_nxt[1:0])
            KIND_DATA:
                good = ok_nxt && (cnt_nxt >= LEN_W'(3)) &&
                       (crc_nxt == CRC16_RESIDUAL) && !len_big;
            KIND_TOKEN:
                good = ok_nxt && (cnt_nxt == LEN_W'(3));
            default:
                good = ok_nxt && (cnt_nxt == LEN_W'(1));
        endcase
        if (rx_abort)
            good = 1'b0;
    end

    always_ff @(posedge clk60m or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            crc     <= CRC16_INIT;
            cur_pid <= 4'h0;
            cur_ok  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            crc     <= crc_nxt;
            cur_pid <= pid_nxt;
            cur_ok  <= ok_nxt;
        end
    end

    always_ff @(posedge clk60m or negedge reset_n) begin
        if (!reset_n) begin
            pkt_pid     <= 4'h0;
            pkt_kind    <= 2'b00;
            pkt_len     <= '0;
            pid_ok      <= 1'b0;
            crc_ok      <= 1'b0;
            len_err     <= 1'b0;
            aborted     <= 1'b0;
            data_toggle <= 1'b0;
        end else if (finish) begin
            pkt_pid  <= pid_nxt;
            pkt_kind <= pid_nxt[1:0];
            pkt_len  <= cnt_nxt;
            pid_ok   <= ok_nxt;
            crc_ok   <= good;
            len_err  <= len_big;
            aborted  <= rx_abort;
            if (pid_nxt[1:0] == KIND_DATA && ok_nxt)
                data_toggle <= pid_nxt[3];
        end
    end

`ifdef USB_RX_STATS_EN
    always_ff @(posedge clk60m or negedge reset_n) begin
        if (!reset_n) begin
            pkt_cnt <= 16'h0;
            err_cnt <= 16'h0;
        end else if (stats_clr) begin
            pkt_cnt <= 16'h0;
            err_cnt <= 16'h0;
        end else if (pkt_done) begin
            if (pkt_cnt != 16'hFFFF)
                pkt_cnt <= pkt_cnt + 16'h1;
            if ((!crc_ok || aborted) && err_cnt != 16'hFFFF)
                err_cnt <= err_cnt + 16'h1;
        end
    end
`endif

endmodule

// File: tb/tb_usb_rx_check.sv
// Directed bench for usb_rx_check; stats checks build when USB_RX_STATS_EN is defined.
module tb_usb_rx_check;

    logic       clk60m = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx_sop = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_byte_valid = 1'b0;
    logic       rx_eop = 1'b0;
    logic       rx_abort = 1'b0;
    logic       busy, pkt_done, pid_ok, crc_ok, len_err, aborted, data_toggle;
    logic [3:0] pkt_pid;
    logic [1:0] pkt_kind;
    logic [6:0] pkt_len;
`ifdef USB_RX_STATS_EN
    logic        stats_clr = 1'b0;
    logic [15:0] err_cnt, pkt_cnt;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int n_done   = 0;
    int d0;

    usb_rx_check dut (
        .clk60m        (clk60m),
        .reset_n       (reset_n),
        .rx_sop        (rx_sop),
        .rx_byte       (rx_byte),
        .rx_byte_valid (rx_byte_valid),
        .rx_eop        (rx_eop),
        .rx_abort      (rx_abort),
        .busy          (busy),
        .pkt_done      (pkt_done),
        .pkt_pid       (pkt_pid),
        .pkt_kind      (pkt_kind),
        .pkt_len       (pkt_len),
        .pid_ok        (pid_ok),
        .crc_ok        (crc_ok),
        .len_err       (len_err),
        .aborted       (aborted),
        .data_toggle   (data_toggle)
`ifdef USB_RX_STATS_EN
        ,
        .stats_clr     (stats_clr),
        .err_cnt       (err_cnt),
        .pkt_cnt       (pkt_cnt)
`endif
    );

    always #8 clk60m = ~clk60m;

    always @(negedge clk60m) if (pkt_done) n_done++;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic sop, input logic vld, input logic [7:0] b,
                         input logic eop, input logic abt);
        rx_sop = sop;
        rx_byte_valid = vld;
        rx_byte = b;
        rx_eop = eop;
        rx_abort = abt;
        @(posedge clk60m);
        #1;
        rx_sop = 1'b0;
        rx_byte_valid = 1'b0;
        rx_eop = 1'b0;
        rx_abort = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk60m);
            #1;
        end
    endtask

    task automatic bytes(input logic [7:0] b);
        drive(1'b0, 1'b1, b, 1'b0, 1'b0);
    endtask

    initial begin
        idle(2);
        chk("rst_done", pkt_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_len", pkt_len, 0);
        chk("rst_crc_ok", crc_ok, 0);
        reset_n = 1'b1;
        idle(1);

        // ACK handshake
        d0 = n_done;
        drive(1, 0, 8'h00, 0, 0);
        chk("ack_busy", busy, 1);
        bytes(8'hD2);
        drive(0, 0, 8'h00, 1, 0);
        chk("ack_done", pkt_done, 1);
        chk("ack_pid", pkt_pid, 4'h2);
        chk("ack_kind", pkt_kind, 2'b10);
        chk("ack_len", pkt_len, 1);
        chk("ack_pid_ok", pid_ok, 1);
        chk("ack_crc_ok", crc_ok, 1);
        chk("ack_aborted", aborted, 0);
        idle(1);
        chk("ack_done_low", pkt_done, 0);
        chk("ack_one_pulse", n_done - d0, 1);
        chk("ack_hold_len", pkt_len, 1);
        chk("ack_idle", busy, 0);

        // zero-length DATA1, good CRC
        drive(1, 0, 8'h00, 0, 0);
        bytes(8'h4B); bytes(8'h00); bytes(8'h00);
        drive(0, 0, 8'h00, 1, 0);
        chk("d1_len", pkt_len, 3);
        chk("d1_kind", pkt_kind, 2'b11);
        chk("d1_crc_ok", crc_ok, 1);
        chk("d1_toggle", data_toggle, 1);
        chk("d1_len_err", len_err, 0);
        idle(1);

        // DATA1 with corrupted CRC byte
        drive(1, 0, 8'h00, 0, 0);
        bytes(8'h4B); bytes(8'h00); bytes(8'h01);
        drive(0, 0, 8'h00, 1, 0);
        chk("d1bad_crc_ok", crc_ok, 0);
        chk("d1bad_pid_ok", pid_ok, 1);
        idle(1);

        // bad PID
        drive(1, 0, 8'h00, 0, 0);
        bytes(8'hD3);
        drive(0, 0, 8'h00, 1, 0);
        chk("badpid_pid_ok", pid_ok, 0);
        chk("badpid_crc_ok", crc_ok, 0);
        idle(1);

        // byte and EOP in the same cycle
        d0 = n_done;
        drive(1, 0, 8'h00, 0, 0);
        drive(0, 1, 8'hD2, 1, 0);
        chk("same_done", pkt_done, 1);
        chk("same_len", pkt_len, 1);
        chk("same_crc_ok", crc_ok, 1);
        idle(2);
        chk("same_one_pulse", n_done - d0, 1);

        // overlength DATA0, 70 bytes
        drive(1, 0, 8'h00, 0, 0);
        bytes(8'hC3);
        for (int i = 0; i < 69; i++) bytes(8'h00);
        drive(0, 0, 8'h00, 1, 0);
        chk("ovl_len", pkt_len, 70);
        chk("ovl_len_err", len_err, 1);
        chk("ovl_crc_ok", crc_ok, 0);
        chk("ovl_toggle", data_toggle, 0);
        idle(1);

        // saturation, 130 bytes
        drive(1, 0, 8'h00, 0, 0);
        bytes(8'hC3);
        for (int i = 0; i < 129; i++) bytes(8'h5A);
        drive(0, 0, 8'h00, 1, 0);
        chk("sat_len", pkt_len, 127);
        chk("sat_len_err", len_err, 1);
        idle(1);

        // abort, with EOP in the same cycle
        drive(1, 0, 8'h00, 0, 0);
        bytes(8'hC3); bytes(8'h11);
        drive(0, 0, 8'h00, 1, 1);
        chk("abt_done", pkt_done, 1);
        chk("abt_aborted", aborted, 1);
        chk("abt_crc_ok", crc_ok, 0);
        chk("abt_len", pkt_len, 2);
        idle(1);

        // restart while busy
        d0 = n_done;
        drive(1, 0, 8'h00, 0, 0);
        bytes(8'hC3);
        drive(1, 0, 8'h00, 0, 0);
        bytes(8'hD2);
        drive(0, 0, 8'h00, 1, 0);
        chk("rst_pid", pkt_pid, 4'h2);
        chk("rst_aborted", aborted, 0);
        idle(2);
        chk("rst_one_pulse", n_done - d0, 1);

        // EOP with no PID byte
        drive(1, 0, 8'h00, 0, 0);
        drive(0, 0, 8'h00, 1, 0);
        chk("nopid_done", pkt_done, 1);
        chk("nopid_len", pkt_len, 0);
        chk("nopid_pid_ok", pid_ok, 0);
        chk("nopid_crc_ok", crc_ok, 0);
        idle(1);

        // traffic in IDLE is ignored
        d0 = n_done;
        drive(0, 1, 8'hD2, 1, 0);
        drive(0, 0, 8'h00, 0, 1);
        idle(2);
        chk("idle_no_pulse", n_done - d0, 0);
        chk("idle_busy", busy, 0);

        // SOP in the DONE cycle
        d0 = n_done;
        drive(1, 0, 8'h00, 0, 0);
        bytes(8'hD2);
        drive(0, 0, 8'h00, 1, 0);
        drive(1, 0, 8'h00, 0, 0);
        chk("sopdone_busy", busy, 1);
        bytes(8'h5A);
        drive(0, 0, 8'h00, 1, 0);
        chk("sopdone_pid", pkt_pid, 4'hA);
        idle(2);
        chk("sopdone_pulses", n_done - d0, 2);

`ifdef USB_RX_STATS_EN
        stats_clr = 1'b1;
        idle(1);
        stats_clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 8'h00, 0, 0);
            bytes(8'hD2);
            drive(0, 0, 8'h00, 1, 0);
        end
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 8'h00, 0, 0);
            bytes(8'hD3);
            drive(0, 0, 8'h00, 1, 0);
        end
        idle(1);
        chk("stats_pkt", pkt_cnt, 5);
        chk("stats_err", err_cnt, 2);
        drive(1, 0, 8'h00, 0, 0);
        bytes(8'hD3);
        drive(0, 0, 8'h00, 1, 0);
        stats_clr = 1'b1;
        idle(1);
        stats_clr = 1'b0;
        chk("stats_clr_pkt", pkt_cnt, 0);
        chk("stats_clr_err", err_cnt, 0);
`endif

        // reset mid-packet
        d0 = n_done;
        drive(1, 0, 8'h00, 0, 0);
        bytes(8'hC3);
        reset_n = 1'b0;
        idle(1);
        chk("mid_busy", busy, 0);
        chk("mid_done", pkt_done, 0);
        chk("mid_len", pkt_len, 0);
        reset_n = 1'b1;
        idle(2);
        chk("mid_no_pulse", n_done - d0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/usb_rx_check.md
Name: usb_rx_check

Overview:
Receive-path packet checker on the clk60m domain, directly downstream of the USB PHY receiver. Consumes the de-stuffed byte stream (SOP, bytes, EOP, abort) the PHY deserialiser produces. Validates the PID, classifies the packet, counts its bytes and checks CRC16 on data packets. Publishes a one-cycle done strobe plus held status, so the PHY can decide whether to ACK and the CPU can read the result.

Parameters:
MAX_LEN, 67, largest legal packet in bytes (PID + 64 payload + 2 CRC); longer packets flag len_err.
LEN_W, 7, width of byte counter and pkt_len.

Ports:
clk60m  input  1  PHY clock; all logic on posedge.
reset_n  input  1  asynchronous active-low reset.
rx_sop  input  1  pulse: new packet starts; first following byte is the PID.
rx_byte  input  8  received byte, LSB = first bit on the wire.
rx_byte_valid  input  1  rx_byte valid this cycle.
rx_eop  input  1  pulse: SE0 seen, packet ended.
rx_abort  input  1  pulse: PHY response timeout or sync loss.
busy  output  1  packet in progress (SOP seen, no EOP/abort yet).
pkt_done  output  1  one-cycle pulse: status outputs updated.
pkt_pid  output  4  PID[3:0] of last packet.
pkt_kind  output  2  00 special, 01 token, 10 handshake, 11 data (= PID[1:0]).
pkt_len  output  LEN_W  bytes received including PID and CRC, saturating at 2^LEN_W-1.
pid_ok  output  1  PID byte present and rx_byte[7:4] == ~rx_byte[3:0].
crc_ok  output  1  packet integrity check passed (rules below).
len_err  output  1  pkt_len > MAX_LEN.
aborted  output  1  last packet ended by rx_abort.
data_toggle  output  1  PID[3] of last data packet (DATA0=0, DATA1=1); holds otherwise.

Behaviour:
- Interface: reset reset_n, asynchronous, active-low; clock clk60m.
- Reset values: all outputs 0; state IDLE; crc register 16'hFFFF.
- States:
  - IDLE: rx_sop -> PID.
  - PID: first valid byte latches pid/pid_ok, count=1 -> BODY.
  - BODY: each valid byte updates CRC16 and count.
  - BODY -> DONE on rx_eop or rx_abort.
  - DONE: drives pkt_done high for one cycle -> IDLE.
- Latency: pkt_done is asserted exactly 1 cycle after the cycle that rx_eop/rx_abort is sampled. Status outputs change only in that cycle and hold until the next pkt_done.
- CRC16 (USB): reflected poly 16'hA001, init 16'hFFFF, byte-serial (8 bit-steps per byte, LSB first). Run over every byte after the PID, including the two CRC bytes. Good residual is 16'hB001.
- crc_ok rules:
  - data: pid_ok & len>=3 & residual==16'hB001 & ~len_err.
  - handshake and special: pid_ok & len==1.
  - token: pid_ok & len==3 (CRC5 not checked).
  - aborted: 0.
- Byte and EOP in the same cycle: the byte is counted and CRC-updated first; the EOP is then applied with the final values.
- EOP in the PID state (no bytes): pkt_done with pid_ok=0, crc_ok=0, pkt_len=0.
- rx_sop while busy: discard the current packet silently (no pkt_done), restart at PID.
- rx_sop in the DONE cycle: accepted; DONE still pulses.
- rx_byte_valid/rx_eop/rx_abort in IDLE: ignored.
- Counter saturates at all-ones, no wrap.
- rx_abort and rx_eop together: abort wins.
- Reset mid-packet returns to IDLE with no pulse.
- data_toggle updates only when pkt_kind==11 and pid_ok.

Optional Feature:
USB_RX_STATS_EN:
- Defined: adds input stats_clr (1) and outputs err_cnt (16) and pkt_cnt (16).
- pkt_cnt increments on every pkt_done.
- err_cnt increments on pkt_done with ~crc_ok | aborted.
- Both counters saturate at 16'hFFFF and reset to 0. stats_clr zeroes them, and a clear wins over an increment in the same cycle.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package usb_pkg: PID constants (OUT 1, IN 9, SOF 5, SETUP D, DATA0 3, DATA1 B, ACK 2, NAK A, STALL E), kind encodings, CRC16_POLY 16'hA001, CRC16_INIT 16'hFFFF, CRC16_RESIDUAL 16'hB001.
- One sub-module, usb_crc16_byte: purely combinational next-CRC from (crc, byte). It is reused by the future transmit CRC generator.

Test Plan:
- ACK handshake: sop, byte D2, eop -> next cycle pkt_done=1, pid=2, kind=10, len=1, pid_ok=1, crc_ok=1.
- Zero-length DATA1: sop, bytes 4B 00 00, eop -> len=3, kind=11, crc_ok=1, data_toggle=1. The same packet with last byte 01 -> crc_ok=0, pid_ok=1.
- Bad PID: sop, byte D3, eop -> pid_ok=0, crc_ok=0. Byte and eop in the same cycle -> len=1, single pkt_done.
- Overlength: DATA0 with 70 bytes total -> len=70, len_err=1, crc_ok=0. 130 bytes -> len=127 (saturated).
- Abort and restart:
  - sop, C3, 11, abort -> aborted=1, crc_ok=0.
  - sop, C3, second sop, D2, eop -> only one pkt_done, pid=2.
- USB_RX_STATS_EN: 3 good and 2 bad packets -> pkt_cnt=5, err_cnt=2. stats_clr asserted in the same cycle as a pkt_done -> both counters 0.
